// File: rtl/rst_ctrl_sonata.sv
// System reset sequencer: synchronizes PLL lock and the board button, debounces the
// button, and releases the active-low system reset after a stretch once all is quiet.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ASSERT    | reset just (re)asserted, one-cycle landing state
// WAIT_LOCK | waiting for synchronized lock and a released button
// STRETCH   | release conditions met, holding reset for StretchCycles
// RUN       | system out of reset, watching for lock/button/software causes
module rst_ctrl_sonata #(
    parameter int SyncStages     = 2,
    parameter int DebounceCycles = 1000,
    parameter int StretchCycles  = 64,
    parameter int LossCntW       = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                locked_pll_i,
    input  logic                ext_rst_ni,
    input  logic                sw_rst_req_i,
    output logic                rst_sys_no,
    output logic                in_reset_o,
    output logic [2:0]          rst_cause_o,
    output logic [LossCntW-1:0] lock_loss_cnt_o
);

    localparam int DbW = $clog2(DebounceCycles);
    localparam int StW = (StretchCycles > 1) ? $clog2(StretchCycles) : 1;

    localparam logic [DbW-1:0]      DbLoad  = DbW'(DebounceCycles - 1);
    localparam logic [DbW-1:0]      DbOne   = DbW'(1);
    localparam logic [StW-1:0]      StLoad  = StW'(StretchCycles - 1);
    localparam logic [StW-1:0]      StOne   = StW'(1);
    localparam logic [LossCntW-1:0] LossOne = LossCntW'(1);

    localparam logic [2:0] CauseLock = 3'b001;
    localparam logic [2:0] CauseBtn  = 3'b010;
    localparam logic [2:0] CauseSw   = 3'b100;

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_WAIT_LOCK,
        ST_STRETCH,
        ST_RUN
    } state_t;

    state_t                state;
    logic [SyncStages-1:0] lock_sync;
    logic [SyncStages-1:0] btn_sync;
    logic                  lock_s;
    logic                  btn_s;
    logic                  btn_db;
    logic [DbW-1:0]        db_cnt;
    logic [StW-1:0]        st_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_sync <= '0;
            btn_sync  <= '1;
        end else begin
            lock_sync <= {lock_sync[SyncStages-2:0], locked_pll_i};
            btn_sync  <= {btn_sync[SyncStages-2:0], ext_rst_ni};
        end
    end

    assign lock_s = lock_sync[SyncStages-1];
    assign btn_s  = btn_sync[SyncStages-1];

    // db_cnt holds the differing samples still needed; any agreeing sample reloads it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            btn_db <= 1'b1;
            db_cnt <= DbLoad;
        end else if (btn_s == btn_db) begin
            db_cnt <= DbLoad;
        end else if (db_cnt == '0) begin
            btn_db <= btn_s;
            db_cnt <= DbLoad;
        end else begin
            db_cnt <= db_cnt - DbOne;
        end
    end

    // rst_sys_no is loaded alongside the state, high only when the next state is RUN.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= ST_ASSERT;
            rst_sys_no      <= 1'b0;
            rst_cause_o     <= CauseLock;
            lock_loss_cnt_o <= '0;
            st_cnt          <= StLoad;
        end else begin
            rst_sys_no <= 1'b0;
            case (state)
                ST_ASSERT: begin
                    state <= ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (lock_s && btn_db) begin
                        state  <= ST_STRETCH;
                        st_cnt <= StLoad;
                    end
                end
                ST_STRETCH: begin
                    if (!lock_s) begin
                        state       <= ST_ASSERT;
                        rst_cause_o <= CauseLock;
                    end else if (!btn_db) begin
                        state       <= ST_ASSERT;
                        rst_cause_o <= CauseBtn;
                    end else if (st_cnt == '0) begin
                        state      <= ST_RUN;
                        rst_sys_no <= 1'b1;
                    end else begin
                        st_cnt <= st_cnt - StOne;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state       <= ST_ASSERT;
                        rst_cause_o <= CauseLock;
                        if (lock_loss_cnt_o != '1) begin
                            lock_loss_cnt_o <= lock_loss_cnt_o + LossOne;
                        end
                    end else if (!btn_db) begin
                        state       <= ST_ASSERT;
                        rst_cause_o <= CauseBtn;
                    end else if (sw_rst_req_i) begin
                        state       <= ST_ASSERT;
                        rst_cause_o <= CauseSw;
                    end else begin
                        rst_sys_no <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_ASSERT;
                end
            endcase
        end
    end

    assign in_reset_o = ~rst_sys_no;

endmodule

// File: tb/tb_rst_ctrl_sonata.sv
// Directed bench for rst_ctrl_sonata: stimulus queues expected reset edges, a
// negedge monitor pops and checks them whenever rst_sys_no changes.
module tb_rst_ctrl_sonata;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       locked_pll_i = 1'b0;
    logic       ext_rst_ni = 1'b1;
    logic       sw_rst_req_i = 1'b0;
    logic       rst_sys_no;
    logic       in_reset_o;
    logic [2:0] rst_cause_o;
    logic [7:0] lock_loss_cnt_o;

    rst_ctrl_sonata dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .locked_pll_i    (locked_pll_i),
        .ext_rst_ni      (ext_rst_ni),
        .sw_rst_req_i    (sw_rst_req_i),
        .rst_sys_no      (rst_sys_no),
        .in_reset_o      (in_reset_o),
        .rst_cause_o     (rst_cause_o),
        .lock_loss_cnt_o (lock_loss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc++;

    typedef struct {
        int         at;
        logic       lvl;
        logic [2:0] cause;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_cnt = 0;
    bit   mon_en  = 1'b0;
    logic prev_rst = 1'b0;

    task automatic push(input int at, input logic lvl, input logic [2:0] cause);
        exp_t e;
        e.at = at; e.lvl = lvl; e.cause = cause; e.cnt = 8'(exp_cnt);
        q.push_back(e);
    endtask

    task automatic bump_loss();
        if (exp_cnt < 255) exp_cnt++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic drained(input string name);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d expected reset edges never seen", name, q.size());
            q.delete();
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    always @(negedge clk_i) begin
        if (mon_en && rst_sys_no !== prev_rst) begin
            prev_rst = rst_sys_no;
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL edge: unexpected rst_sys_no=%0b at cycle %0d", rst_sys_no, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (cyc != e.at || rst_sys_no !== e.lvl || rst_cause_o !== e.cause ||
                    lock_loss_cnt_o !== e.cnt || in_reset_o !== ~e.lvl) begin
                    n_fail++;
                    $display("FAIL edge: got cyc=%0d rst=%0b inr=%0b cause=%03b cnt=%0d, expected cyc=%0d rst=%0b cause=%03b cnt=%0d",
                             cyc, rst_sys_no, in_reset_o, rst_cause_o, lock_loss_cnt_o,
                             e.at, e.lvl, e.cause, e.cnt);
                end
            end
        end
    end

    initial begin
        int c;
        int t;
        int lows[4]  = '{300, 500, 999, 999};
        int highs[4] = '{1, 2, 3, 5};

        // Power-on release
        wait_cyc(4);
        rst_i = 1'b0;
        chk("por_rst_sys_no", 32'(rst_sys_no), 32'd0);
        chk("por_in_reset", 32'(in_reset_o), 32'd1);
        chk("por_cause", 32'(rst_cause_o), 32'b001);
        chk("por_cnt", 32'(lock_loss_cnt_o), 32'd0);
        prev_rst = 1'b0;
        mon_en   = 1'b1;
        c = cyc;
        locked_pll_i = 1'b1;
        push(c + 67, 1'b1, 3'b001);
        wait_cyc(70);
        drained("por_release");

        // Lock loss in RUN, repeated until the counter saturates
        for (int i = 0; i < 300; i++) begin
            c = cyc;
            locked_pll_i = 1'b0;
            bump_loss();
            push(c + 3, 1'b0, 3'b001);
            push(c + 77, 1'b1, 3'b001);
            wait_cyc(10);
            locked_pll_i = 1'b1;
            wait_cyc(70);
        end
        drained("lock_loss");
        chk("loss_saturated", 32'(lock_loss_cnt_o), 32'd255);

        // Bouncy button, no low run long enough to be accepted
        for (int i = 0; i < 4; i++) begin
            ext_rst_ni = 1'b0;
            wait_cyc(lows[i]);
            ext_rst_ni = 1'b1;
            wait_cyc(highs[i]);
        end
        wait_cyc(1010);
        chk("bounce_no_reset", 32'(rst_sys_no), 32'd1);
        drained("bounce");

        // Held press, then held release
        c = cyc;
        ext_rst_ni = 1'b0;
        push(c + 1003, 1'b0, 3'b010);
        wait_cyc(1200);
        c = cyc;
        ext_rst_ni = 1'b1;
        push(c + 1067, 1'b1, 3'b010);
        wait_cyc(1070);
        drained("button");

        // Software reset, plus an ignored pulse during STRETCH
        c = cyc;
        sw_rst_req_i = 1'b1;
        push(c + 1, 1'b0, 3'b100);
        push(c + 67, 1'b1, 3'b100);
        wait_cyc(1);
        sw_rst_req_i = 1'b0;
        wait_cyc(19);
        sw_rst_req_i = 1'b1;
        wait_cyc(1);
        sw_rst_req_i = 1'b0;
        wait_cyc(49);
        drained("sw_reset");

        // Synchronous reset during STRETCH
        c = cyc;
        sw_rst_req_i = 1'b1;
        push(c + 1, 1'b0, 3'b100);
        wait_cyc(1);
        sw_rst_req_i = 1'b0;
        wait_cyc(19);
        rst_i = 1'b1;
        wait_cyc(1);
        chk("mid_stretch_rst", 32'(rst_sys_no), 32'd0);
        chk("mid_stretch_cause", 32'(rst_cause_o), 32'b001);
        chk("mid_stretch_cnt", 32'(lock_loss_cnt_o), 32'd0);
        wait_cyc(1);
        rst_i = 1'b0;
        exp_cnt = 0;
        push(c + 89, 1'b1, 3'b001);
        wait_cyc(70);
        drained("mid_stretch");

        // Synchronous reset during RUN
        c = cyc;
        rst_i = 1'b1;
        push(c + 1, 1'b0, 3'b001);
        wait_cyc(1);
        rst_i = 1'b0;
        push(c + 68, 1'b1, 3'b001);
        wait_cyc(70);
        drained("mid_run");

        // Lock loss, debounced press and sw pulse all hit RUN on cycle t
        c = cyc;
        t = c + 1003;
        ext_rst_ni = 1'b0;
        wait_cyc(1000);
        locked_pll_i = 1'b0;
        wait_cyc(2);
        sw_rst_req_i = 1'b1;
        bump_loss();
        push(t, 1'b0, 3'b001);
        wait_cyc(1);
        sw_rst_req_i = 1'b0;
        ext_rst_ni = 1'b1;
        push(t + 1067, 1'b1, 3'b001);
        wait_cyc(10);
        locked_pll_i = 1'b1;
        wait_cyc(1060);
        drained("simul_all");

        // Button and sw together
        c = cyc;
        t = c + 1003;
        ext_rst_ni = 1'b0;
        wait_cyc(1002);
        sw_rst_req_i = 1'b1;
        push(t, 1'b0, 3'b010);
        wait_cyc(1);
        sw_rst_req_i = 1'b0;
        ext_rst_ni = 1'b1;
        push(t + 1067, 1'b1, 3'b010);
        wait_cyc(1070);
        drained("simul_btn_sw");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
